// File: rtl/divu_seq.sv
// Multi-cycle restoring unsigned divider (DIVU/REMU) with start/valid handshake,
// divide-by-zero and small-dividend shortcuts, and a flush abort.
module divu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            ready,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CNTW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] q_reg, d_reg;
    logic [XLEN:0]   r_reg;
    logic [CNTW-1:0] cnt;

    logic [XLEN:0]   t, r_next;
    logic [XLEN-1:0] q_next;
    logic            ge;
    logic            accept;
    logic            shortcut;

    always_comb begin
        t      = {r_reg[XLEN-1:0], q_reg[XLEN-1]};
        ge     = (t >= {1'b0, d_reg});
        r_next = ge ? (t - {1'b0, d_reg}) : t;
        q_next = {q_reg[XLEN-2:0], ge};
    end

    // A start is only taken when ready, and flush always wins over it.
    always_comb begin
        accept   = start && !flush && (state != CALC);
        shortcut = (divisor == '0) || (dividend < divisor);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = shortcut ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == CALC);
        ready = !busy;
        valid = (state == DONE) && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end else if (dividend < divisor) begin
                quotient  <= '0;
                remainder <= dividend;
            end else begin
                q_reg <= dividend;
                r_reg <= '0;
                d_reg <= divisor;
                cnt   <= CNTW'(XLEN - 1);
            end
        end else if (state == CALC && !flush) begin
            q_reg <= q_next;
            r_reg <= r_next;
            cnt   <= cnt - CNTW'(1);
            if (cnt == '0) begin
                quotient  <= q_next;
                remainder <= r_next[XLEN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: expected results queued at start, checked on valid.
module tb_divu_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [63:0] exp_q[$];

    divu_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .busy     (busy),
        .valid    (valid),
        .quotient (quotient),
        .remainder(remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    // Scoreboard consumer: every valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            check_eq("valid_busy_excl", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 64'd1, 64'd0);
            end else begin
                check_eq("result_qr", {quotient, remainder}, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge where valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int unsigned lat;
        int unsigned n;
        bit          seen;
        bit          busy_ok;
        lat      = (b == 32'd0 || a < b) ? 1 : 33;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        seen     = 1'b0;
        busy_ok  = 1'b1;
        n        = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            if (valid) seen = 1'b1;
            else if (busy != (lat > 1)) busy_ok = 1'b0;
        end
        check_eq("valid_seen", {63'd0, seen}, 64'd1);
        check_eq("latency", 64'(n), 64'(lat));
        check_eq("busy_profile", {63'd0, busy_ok}, 64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_ctrl", {61'd0, ready, busy, valid}, {61'd0, 3'b100});
        check_eq("reset_qr", {quotient, remainder}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7);
        @(negedge clk);
        check_eq("after_done_ctrl", {61'd0, ready, busy, valid}, {61'd0, 3'b100});
        repeat (3) @(negedge clk);
        check_eq("valid_stays_low", {63'd0, valid}, 64'd0);

        run_op(32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        run_op(32'd1234, 32'd0);
        @(negedge clk);
        run_op(32'd5, 32'd9);
        @(negedge clk);

        // back-to-back: second start lands in the DONE cycle of the first
        run_op(32'd100, 32'd7);
        run_op(32'd81, 32'd9);
        @(negedge clk);

        // flush mid-CALC, with an ignored start while busy
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_ignored_busy", {63'd0, busy}, 64'd1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_ctrl", {61'd0, ready, busy, valid}, {61'd0, 3'b100});
        check_eq("flush_keeps_qr", {quotient, remainder}, {32'd9, 32'd0});
        repeat (40) @(negedge clk);
        run_op(32'd50, 32'd5);
        @(negedge clk);

        // asynchronous reset mid-CALC
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ctrl", {61'd0, ready, busy, valid}, {61'd0, 3'b100});
        check_eq("async_rst_qr", {quotient, remainder}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd100, 32'd7);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> (i * 8);
            run_op(a, b);
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
